// File: rtl/approx_mult_engine.sv
// Approximate/exact multiplier engine: reads N operand pairs, normalises, truncates to K bits, multiplies, denormalises, writes 2W-bit results.
// Per-pair latency: 4 (zero operand), 5 (exact), sA+sB+max(sA,sB)+6 (approx); no stall input, memories are assumed always ready.
module approx_mult_engine #(
  parameter int W = 16,
  parameter int K = 8,
  parameter int N = 8,
  localparam int AW  = $clog2(2 * N),
  localparam int RAW = (N > 1) ? $clog2(N) : 1,
  localparam int SW  = $clog2(2 * W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             approx,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [W-1:0]     rd_data,
  output logic             wr_en,
  output logic [RAW-1:0]   wr_addr,
  output logic [2*W-1:0]   wr_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_NORM, S_MUL, S_SHR, S_WR, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_q, b_q;
  logic [2*W-1:0]   out_q;
  logic [SW-1:0]    cnt_q, sa_q, sb_q;
  logic [RAW-1:0]   idx_q;
  logic             mode_q;

  logic [AW-1:0]    pair_base;
  logic [2*W-1:0]   ta, tb, approx_prod, exact_prod;
  logic [SW-1:0]    shift_sum;
  logic             last_pair;
  logic             zero_op;

  assign pair_base   = AW'({idx_q, 1'b0});
  assign ta          = (2*W)'(a_q[W-1:W-K]);
  assign tb          = (2*W)'(b_q[W-1:W-K]);
  // Truncated product is realigned to the top of the 2W result before the denormalising shift.
  assign approx_prod = (ta * tb) << (2*W - 2*K);
  assign exact_prod  = (2*W)'(a_q) * (2*W)'(b_q);
  assign shift_sum   = sa_q + sb_q;
  assign last_pair   = (idx_q == RAW'(N - 1));
  assign zero_op     = (a_q == '0) || (rd_data == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RD_A;
      S_RD_A: begin
        rd_en     = 1'b1;
        rd_addr   = pair_base;
        state_nxt = S_RD_B;
      end
      S_RD_B: begin
        rd_en     = 1'b1;
        rd_addr   = pair_base | AW'(1);
        state_nxt = S_CAP_B;
      end
      S_CAP_B: begin
        if (zero_op)     state_nxt = S_WR;
        else if (mode_q) state_nxt = S_NORM;
        else             state_nxt = S_MUL;
      end
      S_NORM:  if (a_q[W-1] && b_q[W-1]) state_nxt = S_MUL;
      S_MUL: begin
        if (mode_q && (shift_sum != '0)) state_nxt = S_SHR;
        else                             state_nxt = S_WR;
      end
      S_SHR:   if (cnt_q == SW'(1)) state_nxt = S_WR;
      S_WR: begin
        wr_en     = 1'b1;
        wr_addr   = idx_q;
        wr_data   = out_q;
        state_nxt = last_pair ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      sa_q   <= '0;
      sb_q   <= '0;
      idx_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= approx;
            idx_q  <= '0;
          end
        end
        S_RD_B: begin
          a_q  <= rd_data;
          sa_q <= '0;
          sb_q <= '0;
        end
        S_CAP_B: begin
          b_q <= rd_data;
          if (zero_op) out_q <= '0;
        end
        // Each operand stops shifting on its own once its MSB is set.
        S_NORM: begin
          if (!a_q[W-1]) begin
            a_q  <= a_q << 1;
            sa_q <= sa_q + SW'(1);
          end
          if (!b_q[W-1]) begin
            b_q  <= b_q << 1;
            sb_q <= sb_q + SW'(1);
          end
        end
        S_MUL: begin
          out_q <= mode_q ? approx_prod : exact_prod;
          cnt_q <= mode_q ? shift_sum : '0;
        end
        S_SHR: begin
          out_q <= out_q >> 1;
          cnt_q <= cnt_q - SW'(1);
        end
        S_WR:    if (!last_pair) idx_q <= idx_q + RAW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_engine.sv
// Bench for approx_mult_engine: operand memory model, arithmetic reference model and per-cycle output compare.
module tb_approx_mult_engine;
  localparam int W   = 16;
  localparam int K   = 8;
  localparam int N   = 8;
  localparam int AW  = $clog2(2 * N);
  localparam int RAW = (N > 1) ? $clog2(N) : 1;

  logic             clk = 1'b0;
  logic             rst, start, approx;
  logic             busy, done, rd_en, wr_en;
  logic [AW-1:0]    rd_addr;
  logic [W-1:0]     rd_data = '0;
  logic [RAW-1:0]   wr_addr;
  logic [2*W-1:0]   wr_data;

  logic [W-1:0]     opmem [2*N];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Owned by the main process
  bit run_active = 1'b0;
  bit run_mode   = 1'b0;
  int run_seq    = 0;

  // Owned by the compare process
  int seen_seq = 0;
  int exp_idx = 0, done_cnt = 0, rda_cyc = 0, rda_idx = -1;
  bit prev_wr_last = 1'b0, prev_done = 1'b0;
  logic [2*W-1:0] cap_data [N];
  int cap_lat [N];

  approx_mult_engine #(.W(W), .K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .approx(approx),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= opmem[rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lead_shift(input logic [W-1:0] v);
    for (int p = W - 1; p >= 0; p--) if (v[p]) return W - 1 - p;
    return 0;
  endfunction

  function automatic logic [63:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b, input bit m);
    logic [63:0] na, nb, prod;
    int sa, sb;
    if (a == '0 || b == '0) return 64'd0;
    if (!m) return 64'(a) * 64'(b);
    sa = lead_shift(a);
    sb = lead_shift(b);
    na = 64'(a) << sa;
    nb = 64'(b) << sb;
    prod = (na >> (W - K)) * (nb >> (W - K));
    return (prod << (2*W - 2*K)) >> (sa + sb);
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit m);
    int sa, sb;
    if (a == '0 || b == '0) return 4;
    if (!m) return 5;
    sa = lead_shift(a);
    sb = lead_shift(b);
    return sa + sb + ((sa > sb) ? sa : sb) + 6;
  endfunction

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (run_seq != seen_seq) begin
      seen_seq = run_seq;
      exp_idx = 0; done_cnt = 0; rda_idx = -1;
      prev_wr_last = 1'b0; prev_done = 1'b0;
      for (int j = 0; j < N; j++) begin cap_data[j] = '0; cap_lat[j] = -1; end
    end
    if (!rst) begin
      if (!rd_en) chk("rd_addr_zero", 64'(rd_addr), 64'd0);
      if (!wr_en) begin
        chk("wr_addr_zero", 64'(wr_addr), 64'd0);
        chk("wr_data_zero", 64'(wr_data), 64'd0);
      end
      if (!run_active) begin
        chk("idle_rd_en", 64'(rd_en), 64'd0);
        chk("idle_wr_en", 64'(wr_en), 64'd0);
        chk("idle_done",  64'(done),  64'd0);
        chk("idle_busy",  64'(busy),  64'd0);
        prev_wr_last = 1'b0;
        prev_done    = 1'b0;
      end else begin
        if (rd_en) begin
          chk("busy_on_read", 64'(busy), 64'd1);
          if (!rd_addr[0]) begin
            chk("rd_addr_a", 64'(rd_addr), 64'(2 * exp_idx));
            rda_cyc = cyc;
            rda_idx = exp_idx;
          end else begin
            chk("rd_addr_b", 64'(rd_addr), 64'(2 * exp_idx + 1));
          end
        end
        if (wr_en) begin
          if (exp_idx < N) begin
            chk("wr_addr", 64'(wr_addr), 64'(exp_idx));
            chk("wr_data", 64'(wr_data),
                model_res(opmem[2*exp_idx], opmem[2*exp_idx+1], run_mode));
            chk("latency", 64'(cyc - rda_cyc + 1),
                64'(model_lat(opmem[2*exp_idx], opmem[2*exp_idx+1], run_mode)));
            cap_data[exp_idx] = wr_data;
            cap_lat[exp_idx]  = cyc - rda_cyc + 1;
          end else begin
            chk("extra_write", 64'(wr_en), 64'd0);
          end
          exp_idx++;
        end
        if (done || prev_wr_last) chk("done_timing", 64'(done), 64'(prev_wr_last));
        if (done) done_cnt++;
        if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
        prev_wr_last = wr_en && (wr_addr == RAW'(N - 1));
        prev_done    = done;
      end
    end
  end

  task automatic load_directed();
    logic [W-1:0] tbl [2*N];
    tbl = '{16'h00F3, 16'h0005, 16'h1234, 16'h5678, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000,
            16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0003, 16'h8001};
    for (int j = 0; j < 2 * N; j++) opmem[j] = tbl[j];
  endtask

  task automatic do_run(input bit m, input bit pulses);
    bit timed_out;
    run_mode   = m;
    run_seq++;
    run_active = 1'b1;
    start  = 1'b1;
    approx = m;
    @(negedge clk);
    start  = 1'b0;
    approx = ~m;
    timed_out = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
      start = pulses && (t % 7 == 3);
    end
    start = 1'b0;
    if (timed_out) chk("run_timeout", 64'(done_cnt), 64'd1);
    repeat (3) @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("write_count", 64'(exp_idx), 64'(N));
    run_active = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; approx = 1'b0;
    load_directed();
    repeat (2) @(negedge clk);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_rd_en",   64'(rd_en),   64'd0);
    chk("rst_wr_en",   64'(wr_en),   64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_run(1'b1, 1'b0);
    chk("t1_data", 64'(cap_data[0]), 64'h0000_04BF);
    chk("t1_lat",  64'(cap_lat[0]),  64'd40);
    chk("t2_data", 64'(cap_data[1]), 64'h0616_C000);
    chk("t2_lat",  64'(cap_lat[1]),  64'd13);
    chk("t4_zero_a_data", 64'(cap_data[2]), 64'd0);
    chk("t4_zero_a_lat",  64'(cap_lat[2]),  64'd4);
    chk("t4_zero_b_lat",  64'(cap_lat[3]),  64'd4);
    chk("t4_msb_data", 64'(cap_data[4]), 64'h4000_0000);
    chk("t4_msb_lat",  64'(cap_lat[4]),  64'd6);

    do_run(1'b0, 1'b0);
    chk("t3_data", 64'(cap_data[1]), 64'h0626_0060);
    chk("t3_lat",  64'(cap_lat[1]),  64'd5);
    chk("t3_small_data", 64'(cap_data[0]), 64'h0000_04BF);
    chk("t3_max_data", 64'(cap_data[6]), 64'hFFFE_0001);

    for (int j = 0; j < 2 * N; j++) opmem[j] = W'($urandom_range(1, 65535) >> $urandom_range(0, 15));
    do_run(1'b1, 1'b1);

    // Abort a run in the middle of the denormalising shift of pair 3
    for (int j = 0; j < 2 * N; j++) opmem[j] = W'($urandom_range(0, 65535));
    opmem[6] = 16'h0001;
    opmem[7] = 16'h0001;
    run_mode = 1'b1;
    run_seq++;
    run_active = 1'b1;
    start = 1'b1; approx = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (rda_idx == 3) break;
    end
    chk("abort_reach_pair3", 64'(rda_idx), 64'd3);
    repeat (25) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    run_active = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy",    64'(busy),    64'd0);
    chk("abort_wr_en",   64'(wr_en),   64'd0);
    chk("abort_done",    64'(done),    64'd0);
    chk("abort_rd_en",   64'(rd_en),   64'd0);
    chk("abort_wr_data", 64'(wr_data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    load_directed();
    do_run(1'b1, 1'b0);
    chk("restart_data", 64'(cap_data[0]), 64'h0000_04BF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mult_engine.md
Name: approx_mult_engine

Overview:
- Parametrised successor to the fixed-width approximate multiplier top: integrated controller and datapath.
- Processes N operand pairs from an external operand memory. Each pair goes through leading-one normalisation, K-bit truncation, a K×K multiply and a denormalising right shift.
- Each 2W-bit result is written to an external result memory.
- Adds a runtime exact/approximate mode, a zero-operand bypass, and busy/done handshake.

Parameters:
- W, 16, operand width (unsigned); W >= 2.
- K, 8, kept bits per operand after normalisation; 1 <= K <= W (K == W yields exact results).
- N, 8, operand pairs per run; N >= 1.
- Derived localparams:
  - AW = clog2(2N): operand address width.
  - RAW = max(1, clog2(N)): result address width.
  - SW = clog2(2W): shift-count width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- approx  in  1  1 = approximate, 0 = exact; latched when start is accepted
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse after the last result write
- rd_en  out  1  operand memory read strobe
- rd_addr  out  AW  operand address: A of pair i at 2i, B at 2i+1
- rd_data  in  W  operand data, valid the cycle after rd_en (synchronous read, 1-cycle latency)
- wr_en  out  1  result write strobe
- wr_addr  out  RAW  result index i
- wr_data  out  2W  result

Behaviour:

Reset:
- Reset is asynchronous and active-high.
- State -> IDLE. All outputs 0. Internal A, B, out, counters and item index = 0.
- Reset mid-run aborts the run immediately. No partial write is completed and done is not pulsed.

Per-state behaviour (per pair i; "cycle" = one clk):
- IDLE: start=1 -> latch approx, i=0 -> RD_A. start while busy is ignored.
- RD_A: rd_en=1, rd_addr=2i -> RD_B.
- RD_B: rd_en=1, rd_addr=2i+1; A <= rd_data; sA = sB = 0 -> CAP_B.
- CAP_B: B <= rd_data.
  - If A==0 or B==0: out <= 0 -> WR (both modes).
  - Else if approx: -> NORM.
  - Else: -> MUL.
- NORM: A and B each shift left by 1, incrementing sA or sB, only while their own MSB is 0. They stop independently. The first cycle in which both MSBs are 1 performs no shift and -> MUL. Duration = max(sA, sB) + 1 cycles.
- MUL:
  - Approx: out <= (A[W-1:W-K] * B[W-1:W-K]) << (2W-2K); cnt <= sA + sB.
  - Exact: out <= A * B (full 2W); cnt <= 0.
  - cnt == 0 -> WR, else -> SHR.
- SHR: each cycle out <= out >> 1 (logical) and cnt <= cnt - 1. When cnt == 1 this cycle -> WR. Duration = sA + sB cycles.
- WR: wr_en=1, wr_addr=i, wr_data=out.
  - i == N-1 -> DONE.
  - Else i <= i+1 -> RD_A.
- DONE: done=1, busy=1 for this one cycle -> IDLE.

Outputs and timing:
- rd_en, wr_en and done are high only in the states listed above.
- rd_addr, wr_addr and wr_data are 0 when their strobe is low.
- Per-pair latency, RD_A through WR inclusive:
  - Approx, nonzero operands: sA + sB + max(sA, sB) + 6 cycles.
  - Exact, nonzero operands: 5 cycles.
  - Zero operand: 4 cycles.
- Arithmetic: unsigned throughout. The approximate result always truncates (never rounds). No overflow is possible in 2W bits.
- Max shift counts: sA, sB <= W-1; cnt <= 2W-2, which fits in SW bits.
- start held high through DONE: the next run begins only after the IDLE cycle, i.e. start is re-sampled in IDLE.

Test Plan:
1. W=16, K=8, approx=1, pair (0x00F3, 0x0005) -> sA=8, sB=13; wr_data=0x000004BF (1215, exact match); WR occurs 40 cycles after RD_A entry.
2. Approx=1, pair (0x1234, 0x5678) -> truncated 0x91 × 0xAC = 0x616C; wr_data=0x0616C000 (exact is 0x06260060); 13 cycles RD_A to WR.
3. Approx=0, same pair (0x1234, 0x5678) -> wr_data=0x06260060; 5-cycle pair latency; no NORM/SHR states visited.
4. Pairs (0x0000, 0xFFFF) and (0xFFFF, 0x0000) -> wr_data=0, 4-cycle latency each. Pair (0x8000, 0x8000), approx -> 0x40000000 via 1-cycle NORM and no SHR.
5. Full run, N=8, random operands, approx=1 -> wr_addr sequence 0..7; done pulses exactly once, the cycle after the WR with wr_addr=7; busy then falls; start pulses during the run are ignored. Each result equals the reference model (trunc product << (2W-2K)) >> (sA+sB).
6. Assert rst during SHR of pair 3 -> all outputs 0 asynchronously, no wr_en and no done. A new start then processes from pair 0.
